// File: rtl/mem_access_pkg.sv
// mem_access_pkg: op encodings, FSM states, lane-select constants and decode helpers
package mem_access_pkg;
   typedef enum logic [2:0] {
      OP_LB  = 3'd0,
      OP_LBU = 3'd1,
      OP_LH  = 3'd2,
      OP_LHU = 3'd3,
      OP_LW  = 3'd4,
      OP_SB  = 3'd5,
      OP_SH  = 3'd6,
      OP_SW  = 3'd7
   } op_e;
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_e;
   localparam logic [3:0] SEL_B0 = 4'b1000;
   localparam logic [3:0] SEL_H0 = 4'b1100;
   localparam logic [3:0] SEL_H2 = 4'b0011;
   localparam logic [3:0] SEL_W  = 4'b1111;
   function automatic logic is_byte(op_e op);
      return op inside {OP_LB, OP_LBU, OP_SB};
   endfunction
   function automatic logic is_half(op_e op);
      return op inside {OP_LH, OP_LHU, OP_SH};
   endfunction
   function automatic logic is_store(op_e op);
      return op inside {OP_SB, OP_SH, OP_SW};
   endfunction
   function automatic logic is_misaligned(op_e op, logic [1:0] off);
      return (is_half(op) && off[0]) || (!is_byte(op) && !is_half(op) && off != 2'b00);
   endfunction
endpackage

// File: rtl/mem_lane_steer.sv
// mem_lane_steer: big-endian lane select, store replication and load extraction
module mem_lane_steer
   import mem_access_pkg::*;
(
   input  op_e         i_op,
   input  logic [1:0]  i_off,
   input  logic [31:0] i_wdata,
   input  logic [31:0] i_rdata,
   output logic [3:0]  o_sel,
   output logic [31:0] o_wdata,
   output logic [31:0] o_ldata
);
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   // offset 0 is the most significant lane; halfwords pick the upper or lower half
   always_comb begin
      w_byte  = 8'(i_rdata >> {~i_off, 3'b000});
      w_half  = i_off[1] ? i_rdata[15:0] : i_rdata[31:16];
      o_sel   = is_byte(i_op) ? (SEL_B0 >> i_off) : is_half(i_op) ? (i_off[1] ? SEL_H2 : SEL_H0) : SEL_W;
      o_wdata = is_byte(i_op) ? {4{i_wdata[7:0]}} : is_half(i_op) ? {2{i_wdata[15:0]}} : i_wdata;
      o_ldata = (i_op == OP_LB)  ? {{24{w_byte[7]}}, w_byte} :
                (i_op == OP_LBU) ? {24'h0, w_byte} :
                (i_op == OP_LH)  ? {{16{w_half[15]}}, w_half} :
                (i_op == OP_LHU) ? {16'h0, w_half} : i_rdata;
   end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: CPU load/store sequencer onto a word-wide RAM port with wait states
module mem_access_unit
   import mem_access_pkg::*;
#(
   parameter int unsigned WAIT_CYCLES = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  req_op,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        busy,
   output logic        mem_ce,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_sel,
   output logic [31:0] mem_data_o,
   input  logic [31:0] mem_data_i
);
   state_e      r_state, w_next;
   op_e         r_op;
   logic [31:0] r_addr, r_wdata, r_rdata;
   logic [3:0]  r_cnt;
   logic        r_err;
   logic        w_accept, w_last;
   logic [3:0]  w_sel;
   logic [31:0] w_wdata, w_ldata;

   assign w_accept = req_valid && (r_state == ST_IDLE);
   assign w_last   = (r_cnt == 4'(WAIT_CYCLES));

   mem_lane_steer u_steer (
      .i_op    (r_op),
      .i_off   (r_addr[1:0]),
      .i_wdata (r_wdata),
      .i_rdata (mem_data_i),
      .o_sel   (w_sel),
      .o_wdata (w_wdata),
      .o_ldata (w_ldata)
   );

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_next;
   end

   // request capture, wait counter and load-data capture on the last access cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_op    <= OP_LB;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
         r_cnt   <= '0;
         r_err   <= 1'b0;
      end else if (w_accept) begin
         r_op    <= op_e'(req_op);
         r_addr  <= req_addr;
         r_wdata <= req_wdata;
         r_rdata <= '0;
         r_cnt   <= '0;
         r_err   <= is_misaligned(op_e'(req_op), req_addr[1:0]);
      end else if (r_state == ST_ACCESS) begin
         r_cnt <= w_last ? r_cnt : r_cnt + 4'd1;
         if (w_last && !is_store(r_op)) r_rdata <= w_ldata;
      end
   end

   // next state and all outputs; the RAM port is quiet outside ACCESS
   always_comb begin
      w_next     = r_state;
      req_ready  = 1'b0;
      busy       = 1'b1;
      resp_valid = 1'b0;
      resp_rdata = '0;
      resp_err   = 1'b0;
      mem_ce     = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_sel    = '0;
      mem_data_o = '0;
      case (r_state)
         ST_IDLE: begin
            req_ready = 1'b1;
            busy      = 1'b0;
            if (req_valid) w_next = is_misaligned(op_e'(req_op), req_addr[1:0]) ? ST_RESP : ST_ACCESS;
         end
         ST_ACCESS: begin
            mem_ce     = 1'b1;
            mem_we     = is_store(r_op);
            mem_addr   = {r_addr[31:2], 2'b00};
            mem_sel    = w_sel;
            mem_data_o = w_wdata;
            if (w_last) w_next = ST_RESP;
         end
         ST_RESP: begin
            resp_valid = 1'b1;
            resp_rdata = r_rdata;
            resp_err   = r_err;
            w_next     = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end
endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 0: extra memory-wait cycles before read data is sampled (range 0..15).
REQ-002 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  in  1  reset; asynchronous assertion, active-low.
REQ-004 SHALL have port req_valid  in  1  CPU-side access request.
REQ-005 SHALL have port req_ready  out  1  unit idle; request accepted on clk edge when req_valid && req_ready.
REQ-006 SHALL have port req_op  in  3  LB=0, LBU=1, LH=2, LHU=3, LW=4, SB=5, SH=6, SW=7.
REQ-007 SHALL have port req_addr  in  32  byte address.
REQ-008 SHALL have port req_wdata  in  32  store data, right-justified.
REQ-009 SHALL have port resp_valid  out  1  one-cycle completion pulse; no back-pressure.
REQ-010 SHALL have port resp_rdata  out  32  extended load data; 0 for stores and errors.
REQ-011 SHALL have port resp_err  out  1  misaligned access; valid with resp_valid.
REQ-012 SHALL have port busy  out  1  high whenever state != IDLE.
REQ-013 SHALL have ports mem_ce, mem_we (out 1 each), mem_addr (out 32), mem_sel (out 4), mem_data_o (out 32), mem_data_i (in 32): the word-RAM port; RAM writes the selected lanes on the clk edge when ce&&we and returns the combinational read when ce&&!we.

Function
REQ-014 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE; IDLE -> RESP directly for misaligned requests.
REQ-015 SHALL register op, addr and wdata on acceptance; the request inputs are ignored at all other times.
REQ-016 SHALL drive mem_ce=1 only in ACCESS; outside ACCESS, mem_ce, mem_we, mem_sel, mem_addr and mem_data_o are all 0.
REQ-017 SHALL stay in ACCESS for exactly WAIT_CYCLES+1 cycles, counted by a 4-bit counter, and hold all mem_* outputs stable for that period.
REQ-018 SHALL drive mem_addr = {addr[31:2], 2'b00}; mem_we=1 for SB, SH and SW.
REQ-019 SHALL use big-endian lanes: byte offset 0 maps to sel 1000 and bits [31:24]; offset 3 maps to sel 0001 and bits [7:0]. Halfword offset 0 maps to sel 1100; offset 2 maps to sel 0011. Word maps to sel 1111.
REQ-020 SHALL replicate store data: SB puts {4{wdata[7:0]}} on mem_data_o; SH puts {2{wdata[15:0]}}; SW puts wdata.
REQ-021 SHALL capture mem_data_i on the last ACCESS cycle. Extraction: the selected byte or halfword; LB/LH sign-extend; LBU/LHU zero-extend; LW uses the full word.
REQ-022 SHALL flag a request as misaligned when it is a halfword op with addr[0]=1 or a word op with addr[1:0]!=0. Misaligned requests cause no mem_ce pulse and produce resp_err=1 with resp_rdata=0.
REQ-023 SHALL assert resp_valid for exactly one cycle, in RESP. Latency from the accepting edge to resp_valid: WAIT_CYCLES+2 cycles for aligned requests, 1 cycle for misaligned requests.
REQ-024 SHALL drive req_ready = (state==IDLE); back-to-back requests are accepted at the earliest on the cycle after resp_valid.

Reset
REQ-025 SHALL, while rst_n=0, force state=IDLE, counter=0, resp_valid=0, resp_rdata=0, resp_err=0, busy=0, req_ready=1, and all mem_* outputs to 0, with immediate effect (asynchronous).
REQ-026 SHALL abort any in-flight access on reset without a response; a store aborted before its final ACCESS edge may or may not have been written.
REQ-027 SHALL ignore requests presented while rst_n=0.

Structure
REQ-028 SHALL define in package mem_access_pkg: op encodings, FSM state enum, and lane-select constants.
REQ-029 SHALL place lane steering (sel/data generation and load extraction, purely combinational) in sub-module mem_lane_steer; FSM, counter and registers stay in mem_access_unit.

Verification
REQ-030 SHALL test reset: pulse rst_n low mid-ACCESS with WAIT_CYCLES=2 -> mem_ce drops to 0 the same cycle, no resp_valid, req_ready=1.
REQ-031 SHALL test word store/load: SW 0x10 0xDEADBEEF, then LW 0x10 -> mem_sel=1111, resp_rdata=0xDEADBEEF, resp_valid 2 cycles after acceptance.
REQ-032 SHALL test byte ops: SB 0x13 0x000000A5 -> mem_sel=0001, mem_data_o=0xA5A5A5A5; then LB 0x13 -> 0xFFFFFFA5 and LBU 0x13 -> 0x000000A5.
REQ-033 SHALL test halfword loads on RAM word 0x12348001: LH 0x12 -> sel 0011, 0xFFFF8001; LHU 0x12 -> 0x00008001; LH 0x10 -> 0x00001234.
REQ-034 SHALL test misalignment: LW 0x06 and SH 0x05 -> no mem_ce, resp_err=1, resp_rdata=0, resp_valid 1 cycle after acceptance.
REQ-035 SHALL test wait states: WAIT_CYCLES=3, LW 0x20 -> mem_ce high 4 consecutive cycles with stable outputs, resp_valid 5 cycles after acceptance, busy high throughout.
